// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter: parallel-in, serial-out MSB-first transmitter with optional even-parity bit.
// Latency: first frame bit one cycle after accept; done_o one cycle after the last frame bit.
// Backpressure: ready_o low while a frame is in flight; valid_i/data_i are ignored until IDLE.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   data_i       WIDTH-bit word, sampled on an accepted handshake
//   valid_i      request to send data_i
//   ready_o      high in IDLE (decode of the state register)
//   serial_o     registered serial bit, 0 when no frame bit is on the wire
//   bit_valid_o  registered, high in every data or parity bit cycle
//   sof_o        registered, high only with the MSB
//   done_o       registered, one-cycle pulse after the last frame bit
module serial_tx_shifter #(
  parameter int WIDTH  = 8,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             serial_o,
  output logic             bit_valid_o,
  output logic             sof_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             serial_q, serial_d;
  logic             bit_valid_q, bit_valid_d;
  logic             sof_q, sof_d;
  logic             done_q, done_d;

  assign ready_o     = (state_q == IDLE);
  assign serial_o    = serial_q;
  assign bit_valid_o = bit_valid_q;
  assign sof_o       = sof_q;
  assign done_o      = done_q;

  // The serial output is registered, so each branch computes the bit that
  // will be on the wire in the *next* cycle. In DATA, serial_q always equals
  // shift_q's MSB, hence the next bit is shift_q[WIDTH-2].
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    serial_d    = 1'b0;
    bit_valid_d = 1'b0;
    sof_d       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d     = DATA;
          shift_d     = data_i;
          cnt_d       = CW'(WIDTH - 1);
          par_d       = ^data_i;
          serial_d    = data_i[WIDTH-1];
          bit_valid_d = 1'b1;
          sof_d       = 1'b1;
        end
      end
      DATA: begin
        shift_d = shift_q << 1;
        if (cnt_q != '0) begin
          cnt_d       = cnt_q - 1'b1;
          serial_d    = shift_q[WIDTH-2];
          bit_valid_d = 1'b1;
        end else if (PARITY != 0) begin
          state_d     = PAR;
          serial_d    = par_q;
          bit_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      PAR: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      serial_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      serial_q    <= serial_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb_serial_tx_shifter: checks three configurations (W8/no parity, W8/parity, W2/no parity)
// driven from one shared stimulus bus. Directed table and hand sequences plus random traffic,
// all compared against a frame-queue reference model.
module tb_serial_tx_shifter;

  typedef struct packed {
    logic ser;
    logic bv;
    logic sof;
    logic done;
  } out_t;

  // rv = {reset, valid}; exp = {ser, bv, sof, done, rdy} for the W8/no-parity instance
  typedef struct {
    logic [1:0] rv;
    logic [7:0] dat;
    logic [4:0] exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        stim_vld;
  logic [31:0] stim_dat;
  logic [2:0]  ser_w, bv_w, sof_w, done_w, rdy_w;

  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 0;

  out_t mq [3][$];
  out_t cur [3];
  out_t me;
  int   ones;
  int   w;

  vec_t tbl [22];

  serial_tx_shifter #(.WIDTH(8), .PARITY(0)) u_w8p0 (
    .clk(clk), .reset(reset), .data_i(stim_dat[7:0]), .valid_i(stim_vld),
    .ready_o(rdy_w[0]), .serial_o(ser_w[0]), .bit_valid_o(bv_w[0]),
    .sof_o(sof_w[0]), .done_o(done_w[0])
  );

  serial_tx_shifter #(.WIDTH(8), .PARITY(1)) u_w8p1 (
    .clk(clk), .reset(reset), .data_i(stim_dat[7:0]), .valid_i(stim_vld),
    .ready_o(rdy_w[1]), .serial_o(ser_w[1]), .bit_valid_o(bv_w[1]),
    .sof_o(sof_w[1]), .done_o(done_w[1])
  );

  serial_tx_shifter #(.WIDTH(2), .PARITY(0)) u_w2p0 (
    .clk(clk), .reset(reset), .data_i(stim_dat[1:0]), .valid_i(stim_vld),
    .ready_o(rdy_w[2]), .serial_o(ser_w[2]), .bit_valid_o(bv_w[2]),
    .sof_o(sof_w[2]), .done_o(done_w[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wid(input int k);
    return (k == 2) ? 2 : 8;
  endfunction

  function automatic out_t act(input int k);
    out_t a;
    a.ser  = ser_w[k];
    a.bv   = bv_w[k];
    a.sof  = sof_w[k];
    a.done = done_w[k];
    return a;
  endfunction

  task automatic chk_out(input string nm, input int k, input out_t e, input logic er);
    out_t a;
    a = act(k);
    n_vec++;
    if (a !== e || rdy_w[k] !== er) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got ser/bv/sof/done/rdy=%b%b%b%b%b want %b%b%b%b%b",
               nm, k, $time, a.ser, a.bv, a.sof, a.done, rdy_w[k],
               e.ser, e.bv, e.sof, e.done, er);
    end
  endtask

  // Reference model: on an accept, the whole frame's future outputs are
  // enqueued (data bits MSB first, optional parity, then a done cycle).
  // Each edge pops the next cycle's outputs; an empty queue means idle.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        mq[k].delete();
        cur[k] = '0;
      end else begin
        if (!cur[k].bv && stim_vld) begin
          w = wid(k);
          ones = 0;
          for (int b = w - 1; b >= 0; b--) begin
            me.ser  = stim_dat[b];
            me.bv   = 1'b1;
            me.sof  = (b == w - 1);
            me.done = 1'b0;
            if (stim_dat[b]) ones++;
            mq[k].push_back(me);
          end
          if (k == 1) begin
            me.ser  = ones[0];
            me.bv   = 1'b1;
            me.sof  = 1'b0;
            me.done = 1'b0;
            mq[k].push_back(me);
          end
          me = 4'b0001;
          mq[k].push_back(me);
        end
        cur[k] = (mq[k].size() > 0) ? mq[k].pop_front() : out_t'(4'b0000);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) chk_out("model", k, cur[k], !cur[k].bv);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    stim_vld = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Accepts one word, then checks instance k against a hand-derived bit string
  // (first bit at bits[n-1]), the done pulse, and the idle cycle after it.
  task automatic run_frame(input string nm, input int k, input logic [31:0] word,
                           input logic [15:0] bits, input int n);
    out_t e;
    stim_vld = 1'b1;
    stim_dat = word;
    step();
    stim_vld = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.ser  = bits[n-1-i];
      e.bv   = 1'b1;
      e.sof  = (i == 0);
      e.done = 1'b0;
      chk_out(nm, k, e, 1'b0);
      step();
    end
    chk_out({nm, "_done"}, k, 4'b0001, 1'b1);
    step();
    chk_out({nm, "_idle"}, k, 4'b0000, 1'b1);
  endtask

  initial begin
    reset    = 1'b0;
    stim_vld = 1'b0;
    stim_dat = '0;

    //            rv      dat     ser bv sof done rdy
    tbl[0]  = '{2'b00, 8'h00, 5'b00001};  // reset held
    tbl[1]  = '{2'b01, 8'hA5, 5'b00001};  // handshake under reset refused
    tbl[2]  = '{2'b10, 8'h00, 5'b00001};
    tbl[3]  = '{2'b11, 8'hA5, 5'b11100};  // accept A5, MSB=1 with sof
    tbl[4]  = '{2'b11, 8'h3C, 5'b01000};  // busy: 3C ignored
    tbl[5]  = '{2'b10, 8'h3C, 5'b11000};
    tbl[6]  = '{2'b11, 8'h3C, 5'b01000};
    tbl[7]  = '{2'b11, 8'h3C, 5'b01000};
    tbl[8]  = '{2'b11, 8'h3C, 5'b11000};
    tbl[9]  = '{2'b11, 8'h3C, 5'b01000};
    tbl[10] = '{2'b11, 8'h3C, 5'b11000};  // LSB of A5
    tbl[11] = '{2'b11, 8'h3C, 5'b00011};  // done, ready, valid still held
    tbl[12] = '{2'b11, 8'h3C, 5'b01100};  // 3C accepted in done cycle, MSB=0
    tbl[13] = '{2'b10, 8'h00, 5'b01000};
    tbl[14] = '{2'b10, 8'h00, 5'b11000};
    tbl[15] = '{2'b10, 8'h00, 5'b11000};
    tbl[16] = '{2'b10, 8'h00, 5'b11000};
    tbl[17] = '{2'b10, 8'h00, 5'b11000};
    tbl[18] = '{2'b10, 8'h00, 5'b01000};
    tbl[19] = '{2'b10, 8'h00, 5'b01000};
    tbl[20] = '{2'b10, 8'h00, 5'b00011};
    tbl[21] = '{2'b10, 8'h00, 5'b00001};

    step();
    mon_en = 1'b1;

    for (int i = 0; i < 22; i++) begin
      reset    = tbl[i].rv[1];
      stim_vld = tbl[i].rv[0];
      stim_dat = {24'h0, tbl[i].dat};
      step();
      chk_out($sformatf("table%0d", i), 0, tbl[i].exp[4:1], tbl[i].exp[0]);
    end

    // Parity frames: 0x07 has three ones -> parity 1; 0x03 has two -> 0; 0xA5 has four -> 0.
    do_reset();
    run_frame("par07", 1, 32'h07, 16'h000F, 9);
    do_reset();
    run_frame("par03", 1, 32'h03, 16'h0006, 9);
    do_reset();
    run_frame("parA5", 1, 32'hA5, 16'h014A, 9);

    // Minimum width.
    do_reset();
    run_frame("w2", 2, 32'h2, 16'h0002, 2);

    // Reset on the edge that would present the 4th bit of 0xFF.
    do_reset();
    stim_vld = 1'b1;
    stim_dat = 32'hFF;
    step();
    stim_vld = 1'b0;
    chk_out("rst_mid_b1", 0, 4'b1110, 1'b0);
    step();
    chk_out("rst_mid_b2", 0, 4'b1100, 1'b0);
    step();
    chk_out("rst_mid_b3", 0, 4'b1100, 1'b0);
    reset = 1'b0;
    step();
    chk_out("rst_mid_idle", 0, 4'b0000, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_out("rst_mid_nodone", 0, 4'b0000, 1'b1);
    end

    // Random traffic with occasional resets; the monitor compares every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 63) != 0);
      stim_vld = ($urandom_range(0, 3) != 0);
      stim_dat = $urandom;
      step();
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx_shifter.md
# serial_tx_shifter

Parallel-in, serial-out transmitter for the single-bit serial links the registered flop stages in this design capture. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with an optional even-parity bit. It pulses a completion strobe when the frame is done. It is the sending end that drives the d_i-style serial input of downstream capture flops and receivers.

## Interface
- WIDTH, 8, data word width in bits; legal range 2 to 32.
- PARITY, 0, 0 selects no parity bit; 1 appends one even-parity bit after the data bits.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- data_i  input  WIDTH  word to transmit; sampled only on an accepted handshake.
- valid_i  input  1  request to send data_i.
- ready_o  output  1  block can accept a word; equals (state == IDLE).
- serial_o  output  1  serial bit stream; 0 when no bit is being sent.
- bit_valid_o  output  1  high in every cycle serial_o carries a frame bit (data or parity).
- sof_o  output  1  high only in the cycle that carries the first (MSB) bit.
- done_o  output  1  one-cycle pulse in the cycle after the last frame bit.

## Operation
- **State machine.** States are IDLE, DATA and PAR. PAR is reachable only when PARITY=1.
- **IDLE.**
  - ready_o=1, serial_o=0, bit_valid_o=0.
  - On valid_i && ready_o at a rising edge: load shift register ← data_i, bit counter ← WIDTH-1, parity register ← ^data_i, and go to DATA.
- **DATA.**
  - serial_o = shift register MSB, bit_valid_o=1.
  - Each cycle: shift left one bit and decrement the counter.
  - When counter==0: go to PAR if PARITY=1, else to IDLE with done_o=1 in that IDLE cycle.
- **PAR.**
  - serial_o = parity register (XOR of all data bits, so the total number of ones in the frame is even), bit_valid_o=1.
  - Next state is IDLE with done_o=1.
- **Ignored inputs.** valid_i and data_i are ignored outside IDLE; no queuing, no error flag.
- **Reset.** reset low at a rising edge, in any state:
  - Next cycle: state=IDLE, serial_o=0, bit_valid_o=0, sof_o=0, done_o=0, ready_o=1, counter=0, shift register=0.
  - An in-flight frame is abandoned and no done_o is produced for it.
  - A handshake coincident with reset low is not accepted.
- **Output sourcing.**
  - serial_o, bit_valid_o, sof_o and done_o are registered outputs.
  - ready_o is a pure decode of the state register.
- **Counter width.** The counter is $clog2(WIDTH) bits wide and does not wrap in normal operation: it is reloaded on every accept.

## Timing
- **Frame length.** Handshake accepted at edge t:
  - Data bits occupy cycles t+1 .. t+WIDTH, MSB first.
  - With PARITY=1 the parity bit occupies cycle t+WIDTH+1.
- **sof_o.** High in cycle t+1 only.
- **done_o.**
  - High in cycle t+WIDTH+1 when PARITY=0, or t+WIDTH+2 when PARITY=1.
  - That cycle is IDLE, so ready_o=1 in the same cycle.
- **ready_o.** Low from cycle t+1 through the last frame bit cycle inclusive.
- **Back-to-back frames.**
  - A handshake is accepted in the done_o cycle.
  - This gives one IDLE cycle between frames: the minimum gap is 1 cycle with serial_o=0.
- **Latency.** From accept to first bit is 1 cycle.
- **Throughput.** One word per WIDTH+1 cycles (PARITY=0) or WIDTH+2 cycles (PARITY=1).

## Test plan
1. **Reset values.** Hold reset low for 2 cycles, then release → ready_o=1, serial_o=0, bit_valid_o=0, sof_o=0, done_o=0.
2. **Basic frame.** WIDTH=8, PARITY=0, accept 0xA5 at t → serial_o = 1,0,1,0,0,1,0,1 in t+1..t+8; sof_o only at t+1; bit_valid_o high t+1..t+8; done_o only at t+9.
3. **Parity frame.** WIDTH=8, PARITY=1, send 0x07 → data bits 0,0,0,0,0,1,1,1, then parity bit 1 at t+9; done_o at t+10. Send 0x03 → parity bit 0.
4. **Busy, then back-to-back.**
   - Change valid_i/data_i to 0x3C while busy → ignored; 0xA5 is transmitted intact.
   - Hold valid_i=1 with 0x3C continuously → accepted in the done_o cycle t+9; first bit of 0x3C at t+10.
5. **Reset mid-frame.** Drive reset low at the edge of the 4th data bit of 0xFF → next cycle IDLE, serial_o=0, ready_o=1, and no done_o ever appears for that frame.
6. **Minimum width.** WIDTH=2, PARITY=0, send 2'b10 → serial_o 1,0 at t+1..t+2; done_o at t+3.
